pcie_axi_mem_resp: RTL and testbench
====================================

# pcie_axi_mem_resp

AXI4 responder (subordinate) that terminates 128-bit AXI read and write transactions from the PCIe-side AXI initiators into a local single-port SRAM (for example, the AES inbound/outbound buffers). It decodes AW/W/B and AR/R bursts, serialises them onto one memory port and returns OKAY, SLVERR or DECERR responses. It is the far end of the read/write request controllers in the PCIe subsystem.

## Interface
Parameters:
- ID_W, 4, AXI ID width
- MEM_AW, 10, SRAM word-address width; one word is 16 bytes
- BASE_ADDR, 64'h0, byte base of the SRAM window

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- awid/awaddr/awlen/awsize/awburst  in  ID_W/64/8/3/2  write address
- awvalid  in  1; awready  out  1
- wdata/wstrb/wlast  in  128/16/1; wvalid  in  1; wready  out  1
- bid  out  ID_W; bresp  out  2; bvalid  out  1; bready  in  1
- arid/araddr/arlen/arsize/arburst  in  ID_W/64/8/3/2  read address
- arvalid  in  1; arready  out  1
- rid  out  ID_W; rdata  out  128; rresp  out  2; rlast  out  1; rvalid  out  1; rready  in  1
- mem_en  out  1  SRAM access strobe
- mem_we  out  1  write when high
- mem_addr  out  MEM_AW  word address
- mem_wdata  out  128; mem_wstrb  out  16
- mem_rdata  in  128  valid exactly 1 cycle after a read strobe

## Operation
- FSM states: IDLE, WR_DATA, WR_RESP, RD_MEM, RD_DATA. Only one transaction is in flight at a time.
- IDLE:
  - awready and arready are each asserted combinationally only for the granted request.
  - If both awvalid and arvalid are high, priority alternates. A 1-bit last_grant flag resets to read, so the first conflict grants the write.
  - An accepted AW latches id, addr, len, size and burst, clears the beat count and goes to WR_DATA. An accepted AR does the same for the read side and goes to RD_MEM.
- Error classification at address acceptance:
  - Address outside [BASE_ADDR, BASE_ADDR + 2^(MEM_AW+4)) gives DECERR (2'b11).
  - awsize/arsize > 4, or awburst/arburst == 2'b11 (reserved), gives SLVERR (2'b10).
  - WRAP handling is described under Configuration.
  - An errored transaction never asserts mem_en but still completes the full handshake.
- WR_DATA:
  - wready = 1.
  - Each wvalid beat drives mem_en = mem_we = 1 with mem_wstrb = wstrb and mem_addr = current word.
  - On wlast the FSM goes to WR_RESP.
  - If wlast arrives before beat awlen, or beat awlen arrives without wlast, the response becomes SLVERR. Memory writes stop after beat awlen; remaining beats are drained until wlast.
- WR_RESP: bvalid is held with bid and bresp until bready, then the FSM returns to IDLE.
- RD_MEM: one read strobe (mem_en = 1, mem_we = 0), then go to RD_DATA. An errored read skips the strobe and returns rdata = 0.
- RD_DATA:
  - rdata is registered from mem_rdata and rvalid is held until rready.
  - rlast = 1 when the beat count equals arlen.
  - On the last beat handshake go to IDLE; otherwise advance the address and go to RD_MEM.
- Address generation:
  - Byte address advances by 2^size per beat for INCR and is unchanged for FIXED.
  - The word index is addr[MEM_AW+3:4] minus the base; narrow transfers return the full 128-bit word.
  - Address arithmetic is 64-bit. An INCR burst that runs past the window top gets DECERR for the remaining beats.

## Timing
- Reset values: all ready, valid and mem_* outputs are 0; bresp, rresp, rid, bid, rdata and rlast are 0; the state is IDLE.
- Write: AW handshake, then 1 cycle per W beat, then bvalid in the cycle after the wlast handshake.
- Read: AR handshake, then first rvalid 2 cycles later. Sustained rate is one beat per 2 cycles with rready held high.
- rst_n asserted mid-burst aborts the transaction immediately. No B or R response is ever produced for the aborted transaction.
- All valid/data outputs are stable while the peer holds ready low.

## Configuration
- PCIE_AXI_MEM_RESP_WRAP_EN defined:
  - WRAP bursts with awlen/arlen in {1, 3, 7, 15} wrap at boundary (len+1)·2^size.
  - Any other WRAP length gives SLVERR.
- Macro undefined: every WRAP burst gives SLVERR.

## Structure
- Package pcie_axi_pkg holds:
  - burst codes: FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10
  - response codes: OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11
  - the FSM state enum
- Sub-module pcie_axi_addr_gen computes the next byte address, the word index and the in-window flag. It is instantiated once and shared by the read and write paths, since only one path is active at a time.

## Test plan
- Single write of 0x0011…FF to BASE_ADDR + 0x20 with wstrb 16'hFFFF, then a read at the same address with arsize 2 -> bresp 0, rdata 0x0011…FF, rlast 1.
- INCR write with awlen 3 and wstrb 16'h00FF on beat 2 -> 4 SRAM words written, only the low 8 bytes of word 2 changed, bresp 0.
- awvalid and arvalid in the same cycle, twice in succession -> first grant goes to the write, second to the read.
- araddr = BASE_ADDR + 2^(MEM_AW+4) with arlen 1 -> 2 beats with rresp 2'b11 and rdata 0, and mem_en never asserted.
- Write with awlen 2 but wlast on beat 1 -> 2 beats written, bresp 2'b10.
- WRAP read with arlen 3 and arsize 4 at offset 0x30 -> word order 3, 0, 1, 2 with the macro defined; rresp 2'b10 on all 4 beats without it.

Source files
------------

// File: rtl/pcie_axi_mem_resp_pkg.sv
// pcie_axi_pkg: burst/response codes, FSM states and error classifier; WRAP support enabled by PCIE_AXI_MEM_RESP_WRAP_EN.
package pcie_axi_pkg;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_MEM, RD_DATA} state_t;
`ifdef PCIE_AXI_MEM_RESP_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif
  function automatic logic [1:0] classify(logic in_win, logic [2:0] size, logic [1:0] burst, logic [7:0] len);
    logic wrap_bad;
    wrap_bad = burst == WRAP && !(WRAP_EN && len inside {8'd1, 8'd3, 8'd7, 8'd15});
    return !in_win ? DECERR : (size > 3'd4 || burst == 2'b11 || wrap_bad) ? SLVERR : OKAY;
  endfunction
endpackage

// File: rtl/pcie_axi_mem_resp_if.sv
// pcie_axi_mem_resp_if: AXI4 AW/W/B/AR/R bundle, 128-bit data.
interface pcie_axi_mem_resp_if #(parameter int ID_W = 4);
  logic [ID_W-1:0] awid;
  logic [63:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid, awready;
  logic [127:0]    wdata;
  logic [15:0]     wstrb;
  logic            wlast, wvalid, wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid, bready;
  logic [ID_W-1:0] arid;
  logic [63:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid, arready;
  logic [ID_W-1:0] rid;
  logic [127:0]    rdata;
  logic [1:0]      rresp;
  logic            rlast, rvalid, rready;
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/pcie_axi_mem_resp_addr_gen.sv
// pcie_axi_addr_gen: next burst byte address, SRAM word index and window check.
module pcie_axi_addr_gen
  import pcie_axi_pkg::*;
#(
  parameter int          MEM_AW    = 10,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic [63:0]       addr_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  input  logic [7:0]        len_i,
  output logic [63:0]       next_o,
  output logic [MEM_AW-1:0] word_o,
  output logic              in_win_o
);
  logic [63:0] off, inc, mask;
  assign off      = addr_i - BASE_ADDR;
  assign inc      = addr_i + (64'd1 << size_i);
  assign mask     = (({56'd0, len_i} + 64'd1) << size_i) - 64'd1;
  assign in_win_o = addr_i >= BASE_ADDR && (off >> (MEM_AW + 4)) == 64'd0;
  assign word_o   = off[MEM_AW+3:4];
  assign next_o   = burst_i == FIXED ? addr_i :
                    (WRAP_EN && burst_i == WRAP) ? ((addr_i & ~mask) | (inc & mask)) : inc;
endmodule

// File: rtl/pcie_axi_mem_resp.sv
// pcie_axi_mem_resp: AXI4 subordinate serialising one read or write burst at a time onto a single-port SRAM.
module pcie_axi_mem_resp
  import pcie_axi_pkg::*;
#(
  parameter int          ID_W      = 4,
  parameter int          MEM_AW    = 10,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pcie_axi_mem_resp_if.slave   axi,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic [127:0]         mem_wdata,
  output logic [15:0]          mem_wstrb,
  input  logic [127:0]         mem_rdata
);
  state_t          state_q, state_d;
  logic            lg_q, lg_d, fresh_q;
  logic [ID_W-1:0] id_q, id_d;
  logic [63:0]     addr_q, addr_d, ag_addr, next_addr;
  logic [7:0]      len_q, len_d, ag_len;
  logic [2:0]      size_q, size_d, ag_size;
  logic [1:0]      burst_q, burst_d, ag_burst, resp_q, resp_d, rresp_q, rresp_d, beat_err, wr_resp;
  logic [8:0]      cnt_q, cnt_d;
  logic [127:0]    rdata_q;
  logic [MEM_AW-1:0] word;
  logic            in_win, idle, gw, past, wr_en, rd_en;
  assign idle     = state_q == IDLE;
  // Conflicts go to whichever side did not win last time.
  assign gw       = axi.awvalid && (!axi.arvalid || !lg_q);
  assign ag_addr  = !idle ? addr_q  : gw ? axi.awaddr  : axi.araddr;
  assign ag_len   = !idle ? len_q   : gw ? axi.awlen   : axi.arlen;
  assign ag_size  = !idle ? size_q  : gw ? axi.awsize  : axi.arsize;
  assign ag_burst = !idle ? burst_q : gw ? axi.awburst : axi.arburst;
  pcie_axi_addr_gen #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE_ADDR)) u_ag (
    .addr_i(ag_addr), .size_i(ag_size), .burst_i(ag_burst), .len_i(ag_len),
    .next_o(next_addr), .word_o(word), .in_win_o(in_win)
  );
  assign beat_err  = resp_q != OKAY ? resp_q : in_win ? OKAY : DECERR;
  assign past      = cnt_q > {1'b0, len_q};
  assign wr_resp   = past ? resp_q : beat_err != OKAY ? beat_err :
                     (axi.wlast != (cnt_q == {1'b0, len_q})) ? SLVERR : OKAY;
  assign wr_en     = state_q == WR_DATA && axi.wvalid && beat_err == OKAY && !past;
  assign rd_en     = state_q == RD_MEM && beat_err == OKAY;
  assign mem_en    = wr_en || rd_en;
  assign mem_we    = wr_en;
  assign mem_addr  = mem_en ? word : '0;
  assign mem_wdata = wr_en ? axi.wdata : '0;
  assign mem_wstrb = wr_en ? axi.wstrb : '0;
  assign axi.awready = rst_n && idle && gw;
  assign axi.arready = rst_n && idle && axi.arvalid && !gw;
  assign axi.wready  = state_q == WR_DATA;
  assign axi.bvalid  = state_q == WR_RESP;
  assign axi.bid     = id_q;
  assign axi.bresp   = axi.bvalid ? resp_q : OKAY;
  assign axi.rvalid  = state_q == RD_DATA;
  assign axi.rid     = id_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = axi.rvalid && cnt_q == {1'b0, len_q};
  // SRAM data is live only in the first RD_DATA cycle; afterwards the captured copy is held.
  assign axi.rdata   = fresh_q ? (rresp_q == OKAY ? mem_rdata : '0) : rdata_q;
  always_comb begin
    state_d = state_q;
    lg_d    = lg_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    rresp_d = rresp_q;
    case (state_q)
      IDLE: if (axi.awready || axi.arready) begin
        lg_d    = axi.awready;
        id_d    = axi.awready ? axi.awid : axi.arid;
        addr_d  = ag_addr;
        len_d   = ag_len;
        size_d  = ag_size;
        burst_d = ag_burst;
        cnt_d   = '0;
        resp_d  = classify(in_win, ag_size, ag_burst, ag_len);
        state_d = axi.awready ? WR_DATA : RD_MEM;
      end
      WR_DATA: if (axi.wvalid) begin
        cnt_d   = cnt_q + {8'd0, !cnt_q[8]};
        addr_d  = next_addr;
        resp_d  = wr_resp;
        state_d = axi.wlast ? WR_RESP : WR_DATA;
      end
      WR_RESP: state_d = axi.bready ? IDLE : WR_RESP;
      RD_MEM: begin
        rresp_d = beat_err;
        state_d = RD_DATA;
      end
      RD_DATA: if (axi.rready) begin
        addr_d  = next_addr;
        cnt_d   = cnt_q + 9'd1;
        state_d = axi.rlast ? IDLE : RD_MEM;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      lg_q    <= 1'b0;
      fresh_q <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      resp_q  <= OKAY;
      rresp_q <= OKAY;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lg_q    <= lg_d;
      fresh_q <= state_q == RD_MEM;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      rresp_q <= rresp_d;
      rdata_q <= axi.rdata;
    end
endmodule

// File: tb/tb_pcie_axi_mem_resp.sv
// tb_pcie_axi_mem_resp: scoreboard bench for pcie_axi_mem_resp with a behavioural SRAM.
module tb_pcie_axi_mem_resp;
  import pcie_axi_pkg::*;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int MAW = 10;
  typedef struct packed {logic [127:0] d; logic [1:0] r; logic l;} rexp_t;
  logic clk = 0, rst_n = 1;
  logic mem_en, mem_we;
  logic [MAW-1:0] mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic [15:0] mem_wstrb;
  logic [127:0] sram [1024];
  logic [127:0] shadow [1024];
  int en_cnt = 0, wr_cnt = 0, checks = 0, passes = 0;
  rexp_t rq[$];
  logic [5:0] bq[$];
  pcie_axi_mem_resp_if #(.ID_W(4)) axi();
  pcie_axi_mem_resp #(.ID_W(4), .MEM_AW(MAW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .axi(axi), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    mem_rdata <= {4{32'hDEAD_BEEF}};
    if (mem_en) begin
      en_cnt <= en_cnt + 1;
      if (mem_we) begin
        wr_cnt <= wr_cnt + 1;
        for (int b = 0; b < 16; b++) if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else mem_rdata <= sram[mem_addr];
    end
  end

  function automatic logic [127:0] merge(logic [127:0] o, logic [127:0] n, logic [15:0] s);
    for (int b = 0; b < 16; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  task automatic send_a(input bit rd, input logic [63:0] a, input logic [7:0] len, input logic [2:0] sz,
                        input logic [1:0] bu, input logic [3:0] id);
    int n = 0;
    if (rd) begin
      axi.araddr = a; axi.arlen = len; axi.arsize = sz; axi.arburst = bu; axi.arid = id; axi.arvalid = 1;
    end else begin
      axi.awaddr = a; axi.awlen = len; axi.awsize = sz; axi.awburst = bu; axi.awid = id; axi.awvalid = 1;
    end
    #1;
    while (!(rd ? axi.arready : axi.awready) && n < 50) begin @(negedge clk); #1; n++; end
    if (!(rd ? axi.arready : axi.awready)) begin checks++; $display("FAIL %s_timeout", rd ? "ar" : "aw"); end
    @(negedge clk);
    if (rd) axi.arvalid = 0; else axi.awvalid = 0;
  endtask

  task automatic wbeat(input logic [127:0] d, input logic [15:0] s, input logic l);
    int n = 0;
    axi.wdata = d; axi.wstrb = s; axi.wlast = l; axi.wvalid = 1;
    #1;
    while (!axi.wready && n < 50) begin @(negedge clk); #1; n++; end
    if (!axi.wready) begin checks++; $display("FAIL w_timeout"); end
    @(negedge clk);
    axi.wvalid = 0; axi.wlast = 0;
  endtask

  task automatic get_b(output logic [3:0] id, output logic [1:0] r);
    int n = 0;
    axi.bready = 1;
    #1;
    while (!axi.bvalid && n < 50) begin @(negedge clk); #1; n++; end
    if (!axi.bvalid) begin checks++; $display("FAIL b_timeout"); end
    id = axi.bid; r = axi.bresp;
    @(negedge clk);
    axi.bready = 0;
  endtask

  task automatic get_r(output logic [127:0] d, output logic [1:0] r, output logic l, output logic [3:0] id);
    int n = 0;
    axi.rready = 1;
    #1;
    while (!axi.rvalid && n < 50) begin @(negedge clk); #1; n++; end
    if (!axi.rvalid) begin checks++; $display("FAIL r_timeout"); end
    d = axi.rdata; r = axi.rresp; l = axi.rlast; id = axi.rid;
    @(negedge clk);
    axi.rready = 0;
  endtask

  task automatic test_reset();
    axi.awvalid = 1; axi.arvalid = 1;
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid, axi.rlast, mem_en, mem_we} !== 8'd0)
      $display("FAIL reset_ctrl: got %b exp 0", {axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid, axi.rlast, mem_en, mem_we});
    else passes++;
    checks++; if ({axi.bresp, axi.rresp, axi.bid, axi.rid} !== 12'd0)
      $display("FAIL reset_resp: got %h exp 0", {axi.bresp, axi.rresp, axi.bid, axi.rid}); else passes++;
    checks++; if (axi.rdata !== 128'd0) $display("FAIL reset_rdata: got %h exp 0", axi.rdata); else passes++;
    checks++; if ({mem_addr, mem_wdata, mem_wstrb} !== '0) $display("FAIL reset_mem: got %h exp 0", {mem_addr, mem_wdata, mem_wstrb}); else passes++;
    axi.awvalid = 0; axi.arvalid = 0;
    @(negedge clk) rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [127:0] d; logic [1:0] r; logic l; logic [3:0] id; logic [5:0] eb; rexp_t e;
    d = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    send_a(0, BASE + 64'h20, 0, 4, INCR, 3);
    wbeat(d, 16'hFFFF, 1);
    shadow[2] = d; bq.push_back({4'd3, OKAY});
    #1;
    checks++; if (axi.bvalid !== 1'b1) $display("FAIL b_latency: got %b exp 1", axi.bvalid); else passes++;
    get_b(id, r); eb = bq.pop_front();
    checks++; if ({id, r} !== eb) $display("FAIL single_b: got %h exp %h", {id, r}, eb); else passes++;
    send_a(1, BASE + 64'h20, 0, 2, INCR, 5);
    rq.push_back({d, OKAY, 1'b1});
    #1;
    checks++; if (axi.rvalid !== 1'b0) $display("FAIL r_early: got %b exp 0", axi.rvalid); else passes++;
    @(negedge clk); #1;
    checks++; if (axi.rvalid !== 1'b1) $display("FAIL r_latency: got %b exp 1", axi.rvalid); else passes++;
    repeat (3) @(negedge clk);
    get_r(d, r, l, id); e = rq.pop_front();
    checks++; if ({d, r, l, id} !== {e, 4'd5})
      $display("FAIL single_r: got %h/%0d/%0d/%0d exp %h/%0d/%0d/5", d, r, l, id, e.d, e.r, e.l); else passes++;
  endtask

  task automatic test_incr_strobe();
    logic [127:0] d; logic [15:0] s; logic [1:0] r; logic l; logic [3:0] id; logic [5:0] eb; rexp_t e; int w0;
    send_a(0, BASE + 64'h120, 0, 4, INCR, 1);
    wbeat({16{8'hA5}}, 16'hFFFF, 1);
    shadow[18] = {16{8'hA5}};
    get_b(id, r);
    w0 = wr_cnt;
    send_a(0, BASE + 64'h100, 3, 4, INCR, 2);
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      s = i == 2 ? 16'h00FF : 16'hFFFF;
      wbeat(d, s, i == 3);
      shadow[16+i] = merge(shadow[16+i], d, s);
    end
    bq.push_back({4'd2, OKAY});
    get_b(id, r); eb = bq.pop_front();
    checks++; if ({id, r} !== eb) $display("FAIL incr_b: got %h exp %h", {id, r}, eb); else passes++;
    checks++; if (wr_cnt - w0 !== 4) $display("FAIL incr_writes: got %0d exp 4", wr_cnt - w0); else passes++;
    checks++; if (sram[18][127:64] !== {8{8'hA5}}) $display("FAIL incr_strb_hi: got %h exp a5a5a5a5a5a5a5a5", sram[18][127:64]); else passes++;
    send_a(1, BASE + 64'h100, 3, 4, INCR, 2);
    for (int i = 0; i < 4; i++) rq.push_back({shadow[16+i], OKAY, i == 3});
    for (int i = 0; i < 4; i++) begin
      get_r(d, r, l, id); e = rq.pop_front();
      checks++; if ({d, r, l} !== e) $display("FAIL incr_r%0d: got %h/%0d/%0d exp %h/%0d/%0d", i, d, r, l, e.d, e.r, e.l); else passes++;
    end
  endtask

  task automatic test_conflict();
    logic [127:0] d; logic [1:0] r; logic l; logic [3:0] id; logic [5:0] eb; rexp_t e;
    axi.awaddr = BASE + 64'h300; axi.awlen = 0; axi.awsize = 4; axi.awburst = INCR; axi.awid = 7; axi.awvalid = 1;
    axi.araddr = BASE + 64'h20;  axi.arlen = 0; axi.arsize = 4; axi.arburst = INCR; axi.arid = 8; axi.arvalid = 1;
    #1;
    checks++; if ({axi.awready, axi.arready} !== 2'b10) $display("FAIL grant1: got %b exp 10", {axi.awready, axi.arready}); else passes++;
    @(negedge clk) axi.awvalid = 0;
    d = {$urandom, $urandom, $urandom, $urandom};
    wbeat(d, 16'hFFFF, 1); shadow[48] = d;
    bq.push_back({4'd7, OKAY});
    get_b(id, r); eb = bq.pop_front();
    checks++; if ({id, r} !== eb) $display("FAIL grant1_b: got %h exp %h", {id, r}, eb); else passes++;
    axi.awaddr = BASE + 64'h310; axi.awid = 9; axi.awvalid = 1;
    #1;
    checks++; if ({axi.awready, axi.arready} !== 2'b01) $display("FAIL grant2: got %b exp 01", {axi.awready, axi.arready}); else passes++;
    @(negedge clk) axi.arvalid = 0;
    rq.push_back({shadow[2], OKAY, 1'b1});
    get_r(d, r, l, id); e = rq.pop_front();
    checks++; if ({d, r, l, id} !== {e, 4'd8}) $display("FAIL grant2_r: got %h/%0d/%0d/%0d exp %h/%0d/%0d/8", d, r, l, id, e.d, e.r, e.l); else passes++;
    send_a(0, BASE + 64'h310, 0, 4, INCR, 9);
    d = {$urandom, $urandom, $urandom, $urandom};
    wbeat(d, 16'hFFFF, 1); shadow[49] = d;
    bq.push_back({4'd9, OKAY});
    get_b(id, r); eb = bq.pop_front();
    checks++; if ({id, r} !== eb) $display("FAIL grant3_b: got %h exp %h", {id, r}, eb); else passes++;
  endtask

  task automatic test_decerr();
    logic [127:0] d; logic [1:0] r; logic l; logic [3:0] id; rexp_t e; int e0;
    e0 = en_cnt;
    send_a(1, BASE + (64'd1 << (MAW + 4)), 1, 4, INCR, 4);
    for (int i = 0; i < 2; i++) rq.push_back({128'd0, DECERR, i == 1});
    for (int i = 0; i < 2; i++) begin
      get_r(d, r, l, id); e = rq.pop_front();
      checks++; if ({d, r, l} !== e) $display("FAIL decerr_r%0d: got %h/%0d/%0d exp %h/%0d/%0d", i, d, r, l, e.d, e.r, e.l); else passes++;
    end
    checks++; if (en_cnt !== e0) $display("FAIL decerr_mem_en: got %0d strobes exp 0", en_cnt - e0); else passes++;
  endtask

  task automatic test_len_errors();
    logic [1:0] r; logic [3:0] id; logic [5:0] eb; int w0;
    w0 = wr_cnt;
    send_a(0, BASE + 64'h400, 2, 4, INCR, 6);
    wbeat(128'h1111, 16'hFFFF, 0);
    wbeat(128'h2222, 16'hFFFF, 1);
    bq.push_back({4'd6, SLVERR});
    get_b(id, r); eb = bq.pop_front();
    checks++; if ({id, r} !== eb) $display("FAIL early_wlast_b: got %h exp %h", {id, r}, eb); else passes++;
    checks++; if (wr_cnt - w0 !== 2) $display("FAIL early_wlast_writes: got %0d exp 2", wr_cnt - w0); else passes++;
    checks++; if (sram[65] !== 128'h2222) $display("FAIL early_wlast_data: got %h exp 2222", sram[65]); else passes++;
    w0 = wr_cnt;
    send_a(0, BASE + 64'h500, 1, 4, INCR, 6);
    for (int i = 0; i < 3; i++) wbeat(128'h3333 + 128'(i), 16'hFFFF, i == 2);
    bq.push_back({4'd6, SLVERR});
    get_b(id, r); eb = bq.pop_front();
    checks++; if ({id, r} !== eb) $display("FAIL late_wlast_b: got %h exp %h", {id, r}, eb); else passes++;
    checks++; if (wr_cnt - w0 !== 2) $display("FAIL late_wlast_writes: got %0d exp 2", wr_cnt - w0); else passes++;
    w0 = wr_cnt;
    send_a(0, BASE + 64'h700, 0, 5, INCR, 1);
    wbeat(128'h4444, 16'hFFFF, 1);
    bq.push_back({4'd1, SLVERR});
    get_b(id, r); eb = bq.pop_front();
    checks++; if ({id, r} !== eb) $display("FAIL bad_size_b: got %h exp %h", {id, r}, eb); else passes++;
    checks++; if (wr_cnt !== w0) $display("FAIL bad_size_writes: got %0d exp 0", wr_cnt - w0); else passes++;
  endtask

  task automatic test_wrap();
    logic [127:0] d; logic [1:0] r; logic l; logic [3:0] id; rexp_t e;
    int ord[4] = '{35, 32, 33, 34};
    send_a(0, BASE + 64'h200, 3, 4, INCR, 0);
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      wbeat(d, 16'hFFFF, i == 3); shadow[32+i] = d;
    end
    get_b(id, r);
    send_a(1, BASE + 64'h230, 3, 4, WRAP, 1);
    for (int i = 0; i < 4; i++)
`ifdef PCIE_AXI_MEM_RESP_WRAP_EN
      rq.push_back({shadow[ord[i]], OKAY, i == 3});
`else
      rq.push_back({128'd0, SLVERR, i == 3 && ord[i] != 0});
`endif
    for (int i = 0; i < 4; i++) begin
      get_r(d, r, l, id); e = rq.pop_front();
      checks++; if ({d, r, l} !== e) $display("FAIL wrap_r%0d: got %h/%0d/%0d exp %h/%0d/%0d", i, d, r, l, e.d, e.r, e.l); else passes++;
    end
  endtask

  task automatic test_reset_abort();
    send_a(0, BASE + 64'h600, 3, 4, INCR, 2);
    wbeat(128'h5555, 16'hFFFF, 0);
    rst_n = 0;
    #1;
    checks++; if ({axi.wready, mem_en} !== 2'b00) $display("FAIL abort_ready: got %b exp 00", {axi.wready, mem_en}); else passes++;
    @(negedge clk) rst_n = 1;
    axi.bready = 1; axi.rready = 1;
    repeat (4) @(negedge clk);
    checks++; if ({axi.bvalid, axi.rvalid, axi.wready} !== 3'b000) $display("FAIL abort_resp: got %b exp 000", {axi.bvalid, axi.rvalid, axi.wready}); else passes++;
    axi.bready = 0; axi.rready = 0;
  endtask

  initial begin
    {axi.awvalid, axi.arvalid, axi.wvalid, axi.wlast, axi.bready, axi.rready} = '0;
    {axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst} = '0;
    {axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst} = '0;
    {axi.wdata, axi.wstrb} = '0;
    test_reset();
    test_single();
    test_incr_strobe();
    test_conflict();
    test_decerr();
    test_len_errors();
    test_wrap();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
